// File: rtl/retire_trace_buffer_if.sv
// Writeback-to-trace bus: retirement record in, queued record out on valid/ready.
interface retire_trace_buffer_if;
    logic        ret_valid;
    logic [15:0] ret_pc;
    logic [15:0] ret_inst;
    logic        ret_regwrite;
    logic [2:0]  ret_wreg;
    logic [15:0] ret_wdata;
    logic        ret_memread;
    logic        ret_memwrite;
    logic [15:0] ret_memaddr;
    logic [15:0] ret_memdata;
    logic        ret_halt;
    logic        stall_req;
    logic        rec_valid;
    logic        rec_ready;
    logic [86:0] rec_data;
    logic [31:0] rec_inum;

    modport master (
        output ret_valid, ret_pc, ret_inst, ret_regwrite, ret_wreg, ret_wdata,
               ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt, rec_ready,
        input  stall_req, rec_valid, rec_data, rec_inum
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_regwrite, ret_wreg, ret_wdata,
               ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt, rec_ready,
        output stall_req, rec_valid, rec_data, rec_inum
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retirement trace FIFO: numbers each retired instruction, queues it for the trace
// consumer, counts cycles/instructions, and reports halted once a HALT has drained.
module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    retire_trace_buffer_if.slave bus,
    output logic [31:0]          cycle_count,
    output logic [31:0]          inst_count,
    output logic                 halted,
    output logic                 overflow
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);

    state_t            stateReg, stateNext;
    logic [86:0]       dataMem [DEPTH];
    logic [31:0]       inumMem [DEPTH];
    logic [PTR_W-1:0]  wrPtrReg, rdPtrReg;
    logic [PTR_W:0]    countReg, countNext;
    logic [31:0]       cycleReg, instReg;
    logic              overflowReg;
    logic              full, recValid, push, pop, accept, drop;
    logic [86:0]       retRecord;

    assign retRecord = {bus.ret_pc, bus.ret_inst, bus.ret_regwrite, bus.ret_wreg,
                        bus.ret_wdata, bus.ret_memread, bus.ret_memwrite,
                        bus.ret_memaddr, bus.ret_memdata, bus.ret_halt};

    assign full     = (countReg == FULL_COUNT);
    assign recValid = (countReg != '0);
    assign push     = bus.ret_valid && (stateReg == RUN);
    assign pop      = recValid && bus.rec_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still take a push.
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        countNext = countReg;
        case ({accept, pop})
            2'b10:   countNext = countReg + ONE_COUNT;
            2'b01:   countNext = countReg - ONE_COUNT;
            default: countNext = countReg;
        endcase
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            RUN:     if (accept && bus.ret_halt) stateNext = DRAIN;
            DRAIN:   if ((countReg == '0) || ((countReg == ONE_COUNT) && pop)) stateNext = DONE;
            DONE:    stateNext = DONE;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= RUN;
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            cycleReg    <= '0;
            instReg     <= '0;
            overflowReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            if (accept) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
                instReg  <= instReg + 32'd1;
            end
            if (pop) rdPtrReg <= rdPtrReg + PTR_W'(1);
            if (drop) overflowReg <= 1'b1;
            if (stateReg != DONE) cycleReg <= cycleReg + 32'd1;
        end
    end

    // Storage carries no reset; stale entries are hidden by gating on recValid.
    always_ff @(posedge clk) begin
        if (accept) begin
            dataMem[wrPtrReg] <= retRecord;
            inumMem[wrPtrReg] <= instReg;
        end
    end

    assign bus.stall_req = full;
    assign bus.rec_valid = recValid;
    assign bus.rec_data  = recValid ? dataMem[rdPtrReg] : '0;
    assign bus.rec_inum  = recValid ? inumMem[rdPtrReg] : '0;

    assign cycle_count = cycleReg;
    assign inst_count  = instReg;
    assign halted      = (stateReg == DONE);
    assign overflow    = overflowReg;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: expected records queued at push,
// compared at pop; one task per scenario.
module tb_retire_trace_buffer;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [86:0] data;
        logic [31:0] inum;
    } rec_t;
    typedef enum {M_RUN, M_DRAIN, M_DONE} mstate_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cycle_count, inst_count;
    logic        halted, overflow;

    retire_trace_buffer_if bus();

    retire_trace_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .cycle_count(cycle_count), .inst_count(inst_count),
        .halted(halted), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int      compared = 0;
    int      mismatched = 0;
    rec_t    sb[$];
    logic [31:0] mInum, mCycles;
    logic    mOverflow;
    mstate_t mState;

    function automatic logic [86:0] packRet();
        return {bus.ret_pc, bus.ret_inst, bus.ret_regwrite, bus.ret_wreg, bus.ret_wdata,
                bus.ret_memread, bus.ret_memwrite, bus.ret_memaddr, bus.ret_memdata, bus.ret_halt};
    endfunction

    task automatic setRet(input logic v, input logic [15:0] pc, input logic h);
        bus.ret_valid    = v;
        bus.ret_pc       = pc;
        bus.ret_inst     = pc ^ 16'h5A3C;
        bus.ret_regwrite = pc[1];
        bus.ret_wreg     = pc[3:1];
        bus.ret_wdata    = ~pc;
        bus.ret_memread  = pc[2];
        bus.ret_memwrite = pc[3];
        bus.ret_memaddr  = pc + 16'h1000;
        bus.ret_memdata  = {pc[7:0], pc[15:8]};
        bus.ret_halt     = h;
    endtask

    // One clock: score the pop/push seen this cycle, advance, then check status outputs.
    task automatic tick();
        int      cnt;
        logic    popNow, tryPush, pushNow;
        rec_t    e;
        mstate_t nxt;
        cnt     = sb.size();
        popNow  = bus.rec_valid && bus.rec_ready;
        tryPush = bus.ret_valid && (mState == M_RUN);
        pushNow = tryPush && ((cnt < DEPTH) || popNow);
        nxt     = mState;
        if (popNow) begin
            compared++;
            if (cnt == 0) begin
                mismatched++;
                $display("FAIL pop_empty: rec_valid=1 but no record expected");
            end else begin
                e = sb.pop_front();
                if (bus.rec_data !== e.data || bus.rec_inum !== e.inum) begin
                    mismatched++;
                    $display("FAIL pop_record: got inum=%0d data=%h, expected inum=%0d data=%h",
                             bus.rec_inum, bus.rec_data, e.inum, e.data);
                end else begin
                    $display("pop inum=%0d pc=%h", e.inum, e.data[86:71]);
                end
            end
        end
        if (pushNow) begin
            e.data = packRet();
            e.inum = mInum;
            sb.push_back(e);
            mInum++;
            if (bus.ret_halt) nxt = M_DRAIN;
        end
        if (tryPush && !pushNow) mOverflow = 1'b1;
        if (mState != M_DONE) mCycles++;
        if (mState == M_DRAIN && (cnt == 0 || (cnt == 1 && popNow))) nxt = M_DONE;
        mState = nxt;
        @(posedge clk); #1;
        compared += 6;
        if (bus.rec_valid !== (sb.size() != 0)) begin
            mismatched++; $display("FAIL rec_valid: got %b expected %b", bus.rec_valid, sb.size() != 0);
        end
        if (bus.stall_req !== (sb.size() == DEPTH)) begin
            mismatched++; $display("FAIL stall_req: got %b expected %b", bus.stall_req, sb.size() == DEPTH);
        end
        if (inst_count !== mInum) begin
            mismatched++; $display("FAIL inst_count: got %0d expected %0d", inst_count, mInum);
        end
        if (overflow !== mOverflow) begin
            mismatched++; $display("FAIL overflow: got %b expected %b", overflow, mOverflow);
        end
        if (halted !== (mState == M_DONE)) begin
            mismatched++; $display("FAIL halted: got %b expected %b", halted, mState == M_DONE);
        end
        if (cycle_count !== mCycles) begin
            mismatched++; $display("FAIL cycle_count: got %0d expected %0d", cycle_count, mCycles);
        end
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        mInum = 0; mCycles = 0; mOverflow = 1'b0; mState = M_RUN;
        rst_n = 1'b1;
        setRet(1'b0, 16'h0000, 1'b0);
        bus.rec_ready = 1'b0;
    endtask

    task automatic test_reset();
        setRet(1'b1, 16'h0ABC, 1'b0);
        bus.rec_ready = 1'b1;
        doReset(2);
        compared += 8;
        if (bus.stall_req !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req); end
        if (bus.rec_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rec_valid: got %b expected 0", bus.rec_valid); end
        if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b expected 0", halted); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (bus.rec_data !== 87'd0) begin mismatched++; $display("FAIL reset_rec_data: got %h expected 0", bus.rec_data); end
        if (bus.rec_inum !== 32'd0) begin mismatched++; $display("FAIL reset_rec_inum: got %0d expected 0", bus.rec_inum); end
        if (cycle_count !== 32'd0) begin mismatched++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
        if (inst_count !== 32'd0) begin mismatched++; $display("FAIL reset_inst_count: got %0d expected 0", inst_count); end
    endtask

    task automatic test_back_to_back();
        doReset(1);
        bus.rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setRet(1'b1, 16'(2 * i), 1'b0);
            tick();
        end
        setRet(1'b0, 16'h0000, 1'b0);
        compared++;
        if (inst_count !== 32'd3) begin mismatched++; $display("FAIL b2b_inst_count: got %0d expected 3", inst_count); end
        repeat (3) tick();
    endtask

    task automatic test_full_overflow();
        doReset(1);
        for (int i = 0; i < 8; i++) begin
            setRet(1'b1, 16'h0100 + 16'(2 * i), 1'b0);
            tick();
        end
        compared++;
        if (bus.stall_req !== 1'b1) begin mismatched++; $display("FAIL full_stall: got %b expected 1", bus.stall_req); end
        setRet(1'b1, 16'h0200, 1'b0);
        tick();
        compared += 2;
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL drop_overflow: got %b expected 1", overflow); end
        if (inst_count !== 32'd8) begin mismatched++; $display("FAIL drop_inst_count: got %0d expected 8", inst_count); end
        setRet(1'b0, 16'h0000, 1'b0);
        bus.rec_ready = 1'b1;
        repeat (9) tick();
    endtask

    task automatic test_push_pop_full();
        doReset(1);
        for (int i = 0; i < 8; i++) begin
            setRet(1'b1, 16'h0300 + 16'(2 * i), 1'b0);
            tick();
        end
        bus.rec_ready = 1'b1;
        setRet(1'b1, 16'h0400, 1'b0);
        tick();
        compared += 3;
        if (bus.stall_req !== 1'b1) begin mismatched++; $display("FAIL pp_stall: got %b expected 1", bus.stall_req); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        if (inst_count !== 32'd9) begin mismatched++; $display("FAIL pp_inst_count: got %0d expected 9", inst_count); end
        setRet(1'b0, 16'h0000, 1'b0);
        repeat (9) tick();
    endtask

    task automatic test_mem_fields();
        logic [86:0] storeRec, loadRec;
        storeRec = {16'h0040, 16'h7123, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0};
        loadRec  = {16'h0042, 16'h4B80, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0};
        doReset(1);
        bus.ret_valid = 1'b1; bus.ret_pc = 16'h0040; bus.ret_inst = 16'h7123;
        bus.ret_regwrite = 1'b0; bus.ret_wreg = 3'd0; bus.ret_wdata = 16'h0000;
        bus.ret_memread = 1'b0; bus.ret_memwrite = 1'b1; bus.ret_memaddr = 16'h1234;
        bus.ret_memdata = 16'hBEEF; bus.ret_halt = 1'b0;
        tick();
        compared++;
        if (bus.rec_data !== storeRec) begin mismatched++; $display("FAIL store_fields: got %h expected %h", bus.rec_data, storeRec); end
        bus.ret_pc = 16'h0042; bus.ret_inst = 16'h4B80;
        bus.ret_regwrite = 1'b1; bus.ret_wreg = 3'd3; bus.ret_wdata = 16'hBEEF;
        bus.ret_memread = 1'b1; bus.ret_memwrite = 1'b0; bus.ret_memaddr = 16'h1234;
        bus.ret_memdata = 16'h0000;
        tick();
        setRet(1'b0, 16'h0000, 1'b0);
        bus.rec_ready = 1'b1;
        tick();
        compared += 2;
        if (bus.rec_data !== loadRec) begin mismatched++; $display("FAIL load_fields: got %h expected %h", bus.rec_data, loadRec); end
        if (bus.rec_inum !== 32'd1) begin mismatched++; $display("FAIL load_inum: got %0d expected 1", bus.rec_inum); end
        tick();
    endtask

    task automatic test_halt();
        int ticks;
        doReset(1);
        setRet(1'b1, 16'h0500, 1'b0); tick();
        setRet(1'b1, 16'h0502, 1'b0); tick();
        setRet(1'b1, 16'h0504, 1'b1); tick();
        ticks = 3;
        setRet(1'b1, 16'h0600, 1'b0);
        for (int i = 0; i < 30; i++) begin
            bus.rec_ready = (i % 2 == 0);
            tick();
            ticks++;
            if (halted === 1'b1) break;
        end
        compared += 4;
        if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_reached: got %b expected 1", halted); end
        if (inst_count !== 32'd3) begin mismatched++; $display("FAIL halt_inst_count: got %0d expected 3", inst_count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL halt_overflow: got %b expected 0", overflow); end
        if (cycle_count !== 32'(ticks)) begin mismatched++; $display("FAIL halt_cycles: got %0d expected %0d", cycle_count, ticks); end
        repeat (3) tick();
        compared++;
        if (cycle_count !== 32'(ticks)) begin mismatched++; $display("FAIL cycles_frozen: got %0d expected %0d", cycle_count, ticks); end
    endtask

    task automatic test_reset_mid();
        doReset(1);
        for (int i = 0; i < 5; i++) begin
            setRet(1'b1, 16'h0700 + 16'(2 * i), 1'b0);
            tick();
        end
        bus.rec_ready = 1'b1;
        doReset(1);
        compared += 6;
        if (bus.rec_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rec_valid: got %b expected 0", bus.rec_valid); end
        if (bus.rec_data !== 87'd0) begin mismatched++; $display("FAIL mid_rec_data: got %h expected 0", bus.rec_data); end
        if (bus.rec_inum !== 32'd0) begin mismatched++; $display("FAIL mid_rec_inum: got %0d expected 0", bus.rec_inum); end
        if (inst_count !== 32'd0) begin mismatched++; $display("FAIL mid_inst_count: got %0d expected 0", inst_count); end
        if (cycle_count !== 32'd0) begin mismatched++; $display("FAIL mid_cycle_count: got %0d expected 0", cycle_count); end
        if (halted !== 1'b0 || overflow !== 1'b0 || bus.stall_req !== 1'b0) begin
            mismatched++; $display("FAIL mid_flags: got halted=%b overflow=%b stall=%b expected 0", halted, overflow, bus.stall_req);
        end
        setRet(1'b1, 16'h0800, 1'b0);
        tick();
        compared++;
        if (bus.rec_inum !== 32'd0) begin mismatched++; $display("FAIL mid_first_inum: got %0d expected 0", bus.rec_inum); end
        setRet(1'b0, 16'h0000, 1'b0);
        bus.rec_ready = 1'b1;
        tick();
    endtask

    initial begin
        setRet(1'b0, 16'h0000, 1'b0);
        bus.rec_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_full_overflow();
        test_push_pop_full();
        test_mem_fields();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
